// File: rtl/wild_encounter_gen_if.sv
// Handshake bundle between the overworld/battle logic and the wild-encounter generator.
interface wild_encounter_gen_if #(
  parameter int ID_W  = 5,
  parameter int MAP_W = 2
);
  logic [MAP_W-1:0] curr_map;
  logic             step;
  logic             fight_on;
  logic             ack;
  logic             enc_valid;
  logic [ID_W-1:0]  wild_ID;
  logic             in_cooldown;
  logic [7:0]       enc_count;

  modport master (
    output curr_map, step, fight_on, ack,
    input  enc_valid, wild_ID, in_cooldown, enc_count
  );

  modport slave (
    input  curr_map, step, fight_on, ack,
    output enc_valid, wild_ID, in_cooldown, enc_count
  );
endinterface

// File: rtl/wild_encounter_gen.sv
// LFSR-driven wild-encounter generator: rolls chance and weighted species slot,
// offers the encounter via valid/ack, then enforces a frame-counted cooldown.
module wild_encounter_gen #(
  parameter int          ID_W            = 5,
  parameter int          MAP_W           = 2,
  parameter int          SLOTS           = 4,
  parameter int          BASE_ID         = 12,
  parameter int          ENC_THRESH      = 64,
  parameter int          T0              = 96,
  parameter int          T1              = 176,
  parameter int          T2              = 232,
  parameter int          COOLDOWN_FRAMES = 60,
  parameter logic [15:0] SEED            = 16'hACE1
) (
  input logic              frameClk,
  input logic              Reset,
  wild_encounter_gen_if.slave bus
);

  localparam int          MAX_ID    = BASE_ID + ((32'sd1 <<< MAP_W) - 32'sd1) * SLOTS + (SLOTS - 32'sd1);
  localparam logic [8:0]  ENC_T     = 9'(ENC_THRESH);
  localparam logic [8:0]  T0_V      = 9'(T0);
  localparam logic [8:0]  T1_V      = 9'(T1);
  localparam logic [8:0]  T2_V      = 9'(T2);
  localparam logic [15:0] CD_INIT   = 16'(COOLDOWN_FRAMES);
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  if (MAX_ID >= (32'sd1 <<< ID_W)) begin : g_id_range_check
    $error("wild_encounter_gen: highest wild_ID does not fit in ID_W bits");
  end
  if (SEED == 16'h0000) begin : g_seed_check
    $error("wild_encounter_gen: SEED must be nonzero");
  end
  if (!(T0 <= T1 && T1 <= T2 && T2 <= 32'sd256)) begin : g_thresh_check
    $error("wild_encounter_gen: slot thresholds must satisfy T0<=T1<=T2<=256");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ROLL     = 2'd1,
    OFFER    = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic [15:0] shifted;
    shifted = {1'b0, cur[15:1]};
    return cur[0] ? (shifted ^ LFSR_MASK) : shifted;
  endfunction

  state_t           state_r, state_s;
  logic [15:0]      lfsr_r;
  logic [7:0]       chance_s, rarity_s;
  logic [1:0]       slot_s;
  logic [ID_W-1:0]  roll_id_s;
  logic [MAP_W-1:0] map_r, map_s;
  logic [15:0]      cd_r, cd_s;
  logic             enc_valid_r, enc_valid_s;
  logic [ID_W-1:0]  wild_id_r, wild_id_s;
  logic             in_cooldown_r, in_cooldown_s;
  logic [7:0]       enc_count_r, enc_count_s;

  assign chance_s = lfsr_r[7:0];
  assign rarity_s = lfsr_r[15:8];

  // Weighted slot pick from the cumulative 9-bit thresholds.
  always_comb begin
    slot_s = 2'd3;
    if ({1'b0, rarity_s} < T0_V) begin
      slot_s = 2'd0;
    end else if ({1'b0, rarity_s} < T1_V) begin
      slot_s = 2'd1;
    end else if ({1'b0, rarity_s} < T2_V) begin
      slot_s = 2'd2;
    end else begin
      slot_s = 2'd3;
    end
  end

  assign roll_id_s = ID_W'(BASE_ID) + ID_W'(bus.curr_map) * ID_W'(SLOTS) + ID_W'(slot_s);

  // FSM state register.
  always_ff @(posedge frameClk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s       = state_r;
    enc_valid_s   = enc_valid_r;
    wild_id_s     = wild_id_r;
    map_s         = map_r;
    cd_s          = cd_r;
    in_cooldown_s = in_cooldown_r;
    enc_count_s   = enc_count_r;
    case (state_r)
      IDLE: begin
        if (bus.step && !bus.fight_on && ({1'b0, chance_s} < ENC_T)) begin
          state_s = ROLL;
        end else begin
          state_s = IDLE;
        end
      end
      ROLL: begin
        wild_id_s   = roll_id_s;
        map_s       = bus.curr_map;
        enc_valid_s = 1'b1;
        state_s     = OFFER;
      end
      OFFER: begin
        // ack has priority over a simultaneous map change.
        if (bus.ack) begin
          enc_valid_s   = 1'b0;
          cd_s          = CD_INIT;
          in_cooldown_s = (CD_INIT != 16'd0);
          enc_count_s   = (enc_count_r == 8'hFF) ? enc_count_r : enc_count_r + 8'd1;
          state_s       = COOLDOWN;
        end else if (bus.curr_map != map_r) begin
          enc_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = OFFER;
        end
      end
      COOLDOWN: begin
        if (cd_r == 16'd0) begin
          in_cooldown_s = 1'b0;
          state_s       = IDLE;
        end else if (bus.fight_on) begin
          state_s = COOLDOWN;
        end else begin
          cd_s          = cd_r - 16'd1;
          in_cooldown_s = (cd_r != 16'd1);
          state_s       = (cd_r == 16'd1) ? IDLE : COOLDOWN;
        end
      end
      default: begin
        enc_valid_s   = 1'b0;
        in_cooldown_s = 1'b0;
        state_s       = IDLE;
      end
    endcase
  end

  // Free-running LFSR and registered datapath/outputs.
  always_ff @(posedge frameClk or posedge Reset) begin
    if (Reset) begin
      lfsr_r        <= SEED;
      map_r         <= '0;
      cd_r          <= 16'd0;
      enc_valid_r   <= 1'b0;
      wild_id_r     <= '0;
      in_cooldown_r <= 1'b0;
      enc_count_r   <= 8'd0;
    end else begin
      lfsr_r        <= lfsr_next(lfsr_r);
      map_r         <= map_s;
      cd_r          <= cd_s;
      enc_valid_r   <= enc_valid_s;
      wild_id_r     <= wild_id_s;
      in_cooldown_r <= in_cooldown_s;
      enc_count_r   <= enc_count_s;
    end
  end

  assign bus.enc_valid   = enc_valid_r;
  assign bus.wild_ID     = wild_id_r;
  assign bus.in_cooldown = in_cooldown_r;
  assign bus.enc_count   = enc_count_r;

endmodule

// File: tb/tb_wild_encounter_gen.sv
// Directed bench for wild_encounter_gen: three instances cover forced encounters,
// never-encounter, and default statistics with a hand-traced LFSR sequence.
module tb_wild_encounter_gen;

  logic frameClk = 1'b0;
  logic rst_a    = 1'b1;
  logic rst_bc   = 1'b1;
  int   total_checks  = 0;
  int   passed_checks = 0;
  int   failed_checks = 0;

  always #5 frameClk = ~frameClk;

  wild_encounter_gen_if #(.ID_W(5), .MAP_W(2)) if_a ();
  wild_encounter_gen_if #(.ID_W(5), .MAP_W(2)) if_b ();
  wild_encounter_gen_if #(.ID_W(5), .MAP_W(2)) if_c ();

  wild_encounter_gen #(
    .ENC_THRESH(256), .T0(256), .T1(256), .T2(256), .COOLDOWN_FRAMES(4)
  ) dut_a (.frameClk(frameClk), .Reset(rst_a), .bus(if_a));

  wild_encounter_gen #(
    .ENC_THRESH(0)
  ) dut_b (.frameClk(frameClk), .Reset(rst_bc), .bus(if_b));

  wild_encounter_gen #(
    .COOLDOWN_FRAMES(0)
  ) dut_c (.frameClk(frameClk), .Reset(rst_bc), .bus(if_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else begin
      failed_checks++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag,
                            input logic ev, input logic [4:0] id, input logic cd, input logic [7:0] cnt,
                            input logic x_ev, input logic [4:0] x_id, input logic x_cd, input logic [7:0] x_cnt);
    check({tag, ".enc_valid"},   32'(ev),  32'(x_ev));
    check({tag, ".wild_ID"},     32'(id),  32'(x_id));
    check({tag, ".in_cooldown"}, 32'(cd),  32'(x_cd));
    check({tag, ".enc_count"},   32'(cnt), 32'(x_cnt));
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge frameClk);
      #1;
    end
  endtask

  `define OUTS_A if_a.enc_valid, if_a.wild_ID, if_a.in_cooldown, if_a.enc_count
  `define OUTS_C if_c.enc_valid, if_c.wild_ID, if_c.in_cooldown, if_c.enc_count

  initial begin
    int steps, hits, bad_ids, band_ok;
    int hist [4];
    int exp_pm [4];
    logic seen_valid;
    exp_pm = '{3750, 3125, 2188, 938};
    hist   = '{0, 0, 0, 0};
    if_a.curr_map = 2'd2; if_a.step = 1'b0; if_a.fight_on = 1'b0; if_a.ack = 1'b0;
    if_b.curr_map = 2'd1; if_b.step = 1'b0; if_b.fight_on = 1'b0; if_b.ack = 1'b0;
    if_c.curr_map = 2'd1; if_c.step = 1'b0; if_c.fight_on = 1'b0; if_c.ack = 1'b0;
    tick(2);
    check_outs("reset_a", `OUTS_A, 1'b0, 5'd0, 1'b0, 8'd0);

    // Forced encounter on map 2, slot 0: id 12 + 2*4 = 20.
    rst_a = 1'b0;
    if_a.step = 1'b1;
    tick();
    if_a.step = 1'b0;
    check_outs("t1_edge1", `OUTS_A, 1'b0, 5'd0, 1'b0, 8'd0);
    tick();
    check_outs("t1_edge2", `OUTS_A, 1'b1, 5'd20, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_outs("t1_hold", `OUTS_A, 1'b1, 5'd20, 1'b0, 8'd0);
    end
    if_a.ack = 1'b1;
    tick();
    if_a.ack = 1'b0;
    check_outs("t1_ack", `OUTS_A, 1'b0, 5'd20, 1'b1, 8'd1);

    // Cooldown frozen during a fight, then exactly 4 frames; steps ignored.
    if_a.fight_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_frozen", 32'(if_a.in_cooldown), 32'd1);
    end
    if_a.fight_on = 1'b0;
    if_a.step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_counting", 32'(if_a.in_cooldown), 32'd1);
    end
    tick();
    if_a.step = 1'b0;
    check_outs("t2_done", `OUTS_A, 1'b0, 5'd20, 1'b0, 8'd1);
    tick(2);
    check_outs("t2_no_offer", `OUTS_A, 1'b0, 5'd20, 1'b0, 8'd1);
    if_a.ack = 1'b1;
    tick();
    if_a.ack = 1'b0;
    check_outs("t2_idle_ack", `OUTS_A, 1'b0, 5'd20, 1'b0, 8'd1);

    // Map change withdraws the offer; map change plus ack is accepted.
    if_a.step = 1'b1; tick(); if_a.step = 1'b0; tick();
    check("t4_offer", 32'(if_a.enc_valid), 32'd1);
    if_a.curr_map = 2'd3;
    tick();
    check_outs("t4_withdraw", `OUTS_A, 1'b0, 5'd20, 1'b0, 8'd1);
    if_a.step = 1'b1; tick(); if_a.step = 1'b0; tick();
    check_outs("t4_map3_offer", `OUTS_A, 1'b1, 5'd24, 1'b0, 8'd1);
    if_a.curr_map = 2'd2;
    if_a.ack = 1'b1;
    tick();
    if_a.ack = 1'b0;
    check_outs("t4_ack_wins", `OUTS_A, 1'b0, 5'd24, 1'b1, 8'd2);
    tick(4);
    check_outs("t4_cd_end", `OUTS_A, 1'b0, 5'd24, 1'b0, 8'd2);

    // Asynchronous reset mid-OFFER and mid-COOLDOWN.
    if_a.step = 1'b1; tick(); if_a.step = 1'b0; tick();
    check_outs("t5_offer", `OUTS_A, 1'b1, 5'd20, 1'b0, 8'd2);
    #3 rst_a = 1'b1;
    #1 check_outs("t5_rst_offer", `OUTS_A, 1'b0, 5'd0, 1'b0, 8'd0);
    @(posedge frameClk); #1 rst_a = 1'b0;
    if_a.step = 1'b1; tick(); if_a.step = 1'b0; tick();
    check_outs("t5_again", `OUTS_A, 1'b1, 5'd20, 1'b0, 8'd0);
    if_a.ack = 1'b1; tick(); if_a.ack = 1'b0; tick();
    check_outs("t5_in_cd", `OUTS_A, 1'b0, 5'd20, 1'b1, 8'd1);
    #3 rst_a = 1'b1;
    #1 check_outs("t5_rst_cd", `OUTS_A, 1'b0, 5'd0, 1'b0, 8'd0);
    @(posedge frameClk); #1 rst_a = 1'b0;

    // Default params, map 1, step and ack held from the first edge after reset.
    // LFSR from ACE1: chance hits at s2 (0x38) and s6 (0x13); rarity 0x38 -> slot 0, 0xED -> slot 3.
    rst_bc = 1'b0;
    if_c.step = 1'b1;
    if_c.ack = 1'b1;
    tick(4);
    check_outs("t5_det_first", `OUTS_C, 1'b1, 5'd16, 1'b0, 8'd0);
    tick(4);
    check_outs("t5_det_second", `OUTS_C, 1'b1, 5'd19, 1'b0, 8'd1);
    if_c.step = 1'b0;
    tick();
    if_c.ack = 1'b0;
    tick();

    // Threshold 0 never offers.
    seen_valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if_b.step = 1'b1; tick(); seen_valid |= if_b.enc_valid;
      if_b.step = 1'b0; tick(); seen_valid |= if_b.enc_valid;
    end
    check("t3_never_valid", 32'(seen_valid), 32'd0);
    check("t3_count", 32'(if_b.enc_count), 32'd0);

    // Statistics with default thresholds, every offer acked.
    steps = 0; hits = 0; bad_ids = 0;
    for (int i = 0; i < 20000; i++) begin
      if_c.step = 1'b1; tick(); if_c.step = 1'b0;
      steps++;
      tick();
      if (if_c.enc_valid) begin
        hits++;
        if (if_c.wild_ID >= 5'd16 && if_c.wild_ID <= 5'd19) hist[int'(if_c.wild_ID) - 16]++;
        else bad_ids++;
        if_c.ack = 1'b1; tick(); if_c.ack = 1'b0; tick();
      end
    end
    $display("stats: steps=%0d hits=%0d slots=%0d/%0d/%0d/%0d", steps, hits, hist[0], hist[1], hist[2], hist[3]);
    band_ok = (hits * 100 >= 23 * steps && hits * 100 <= 27 * steps) ? 1 : 0;
    check("t6_rate_band", 32'(band_ok), 32'd1);
    for (int k = 0; k < 4; k++) begin
      band_ok = (hist[k] * 10000 >= (exp_pm[k] - 300) * hits &&
                 hist[k] * 10000 <= (exp_pm[k] + 300) * hits) ? 1 : 0;
      check($sformatf("t6_slot%0d_band", k), 32'(band_ok), 32'd1);
    end
    check("t6_bad_ids", 32'(bad_ids), 32'd0);
    check("t6_count_sat", 32'(if_c.enc_count), 32'd255);

    // Reset mid-run reproduces the same species sequence.
    #3 rst_bc = 1'b1;
    #1 check_outs("t5_rst_c", `OUTS_C, 1'b0, 5'd0, 1'b0, 8'd0);
    @(posedge frameClk); #1 rst_bc = 1'b0;
    if_c.step = 1'b1;
    if_c.ack = 1'b1;
    tick(4);
    check_outs("t5_rep_first", `OUTS_C, 1'b1, 5'd16, 1'b0, 8'd0);
    tick(4);
    check_outs("t5_rep_second", `OUTS_C, 1'b1, 5'd19, 1'b0, 8'd1);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
